axi4_write_slave_mem: RTL
=========================

# axi4_write_slave_mem

Parametrised AXI4 write-channel slave with an internal word-addressed memory. It is the next generation of the single-ID, INCR-only write FSM. New behaviour: configurable data/address/ID widths and memory depth, FIXED/INCR/WRAP bursts, WSTRB byte enables, BID echo, and SLVERR reporting for bad bursts. It sits behind the interconnect as a simulation/bring-up target and is read back through a debug port.

## Interface
- DATA_W, 32: data width in bits; 32, 64 or 128.
- ADDR_W, 32: AWADDR width.
- ID_W, 4: AWID/BID width.
- MEM_DEPTH, 64: memory depth in DATA_W words; power of two.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- AWID  in  ID_W  write transaction ID.
- AWADDR  in  ADDR_W  byte start address.
- AWLEN  in  8  beats minus one.
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- AWVALID / AWREADY  in / out  1  address handshake.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- WLAST  in  1  last beat marker.
- WVALID / WREADY  in / out  1  data handshake.
- BID  out  ID_W  echo of captured AWID.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- BVALID / BREADY  out / in  1  response handshake.
- dbg_addr  in  log2(MEM_DEPTH)  debug word index.
- dbg_rdata  out  DATA_W  mem[dbg_addr], combinational.

## Operation
- OFF = log2(DATA_W/8). Word index = AWADDR >> OFF, kept at full ADDR_W-OFF width. AWSIZE is not supported; every beat is full width.
- One outstanding transaction. States: IDLE, DATA, RESP.
- IDLE: AWREADY=1, WREADY=0. On AW handshake, capture the ID, word index, AWLEN and burst; clear beat_cnt and err; go to DATA.
- A write channel that leads AW is stalled: WREADY stays 0 until DATA.
- DATA: AWREADY=0, WREADY=1. On each W handshake, write every byte lane with WSTRB[i]=1 into mem[idx]. Lanes with WSTRB[i]=0 are unchanged.
- After each beat, idx advances:
  - FIXED: idx unchanged.
  - INCR: idx+1.
  - WRAP: idx+1 within a window of AWLEN+1 words aligned to that size. The low log2(AWLEN+1) bits wrap and the high bits are held.
- The burst ends on the handshake where beat_cnt==AWLEN; the state then goes to RESP. WLAST does not end the burst.
- Error conditions set err. The beat is still consumed.
  - WLAST differs from (beat_cnt==AWLEN) on any beat.
  - idx >= MEM_DEPTH: the write is suppressed.
  - AWBURST==11: all writes in the burst are suppressed.
  - WRAP with AWLEN not in {1,3,7,15}: all writes in the burst are suppressed.
- RESP: BVALID=1, BID=captured ID, BRESP=err?10:00. Hold until BREADY, then go to IDLE.
- Memory contents are not reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, BID=0. State=IDLE, beat_cnt=0, err=0.
- AWREADY is 1 in the first cycle after ARESET deasserts. All handshake outputs are registered.
- The AW handshake in cycle T gives WREADY=1 from T+1.
- A burst of N beats with WVALID held high takes N cycles of DATA. The last handshake in cycle T gives WREADY=0 and BVALID=1 at T+1.
- The B handshake in cycle T gives BVALID=0 and AWREADY=1 at T+1. Minimum turnaround is 3 cycles for a 1-beat burst.
- A WVALID gap holds the state and idx. BREADY low holds BVALID, BID and BRESP stable.
- AWVALID during DATA or RESP is not accepted.
- A memory write is visible on dbg_rdata in the cycle after the handshake.
- ARESET asserted mid-burst returns the block to IDLE with reset values on the next edge. Words already written stay written and no response is issued.
- beat_cnt is 8 bits and never exceeds AWLEN.

## Test plan
- INCR, AWADDR=0x10, AWLEN=3, AWID=5, data 0xA0..0xA3, WSTRB=F -> mem[4..7]=A0..A3; BID=5, BRESP=00; one beat per cycle.
- WRAP, AWADDR=0x38, AWLEN=3, data D0..D3 -> writes land at words 14,15,12,13; BRESP=00.
- FIXED, AWADDR=0x8, AWLEN=2, WSTRB 0x1, 0x2, 0xC, data 0x11111111, 0x22222222, 0x33333333 on a pre-zeroed word -> mem[2]=0x33332211.
- W presented 3 cycles before AW -> WREADY=0 until the cycle after the AW handshake. Then BREADY held low 4 cycles -> BVALID and BRESP stable.
- INCR, AWADDR=0xF8, AWLEN=3 (MEM_DEPTH=64) -> words 62,63 written, 64,65 suppressed, BRESP=10. Separately, WLAST on beat 1 of AWLEN=3 -> 4 beats consumed, BRESP=10.
- ARESET pulsed after beat 2 of 4 -> AWREADY=0, WREADY=0, BVALID=0, no B response. A following 1-beat burst completes with BRESP=00.

Source files
------------

// File: rtl/axi4_write_slave_mem.sv
// AXI4 write-channel slave backed by a word-addressed memory with a combinational debug read port.
// Single outstanding transaction; FIXED/INCR/WRAP bursts, byte strobes, BID echo, SLVERR on bad bursts.
module axi4_write_slave_mem #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 64
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ID_W-1:0]              AWID,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [1:0]                   AWBURST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [DATA_W/8-1:0]          WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [ID_W-1:0]              BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_nxt;

  logic [ID_W-1:0]        id_q;
  logic [IDX_W-1:0]       idx_q, idx_nxt, aw_idx, wrap_mask;
  logic [7:0]             len_q;
  logic [7:0]             beat_cnt_q;
  logic [1:0]             burst_q;
  logic                   err_q, err_nxt;

  logic                   awready_q, wready_q, bvalid_q;
  logic [1:0]             bresp_q;
  logic                   awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]             bresp_nxt;

  logic                   aw_fire, w_fire, b_fire;
  logic                   last_beat, burst_bad, in_range, wr_en;

  logic [DATA_W-1:0]      mem [MEM_DEPTH];

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = id_q;

  assign aw_fire = AWVALID && awready_q;
  assign w_fire  = WVALID && wready_q;
  assign b_fire  = bvalid_q && BREADY;

  assign aw_idx    = IDX_W'(AWADDR >> OFF);
  assign last_beat = (beat_cnt_q == len_q);
  assign in_range  = (idx_q < IDX_W'(MEM_DEPTH));
  assign wrap_mask = IDX_W'(len_q);

  // Reserved burst type, or a WRAP whose length is not a power of two (2..16), writes nothing.
  assign burst_bad = (burst_q == 2'b11) ||
                     ((burst_q == 2'b10) &&
                      !((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15)));

  // A reset edge must not land a stray beat in memory.
  assign wr_en = w_fire && in_range && !burst_bad && !ARESET;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (aw_fire)             state_nxt = S_DATA;
      S_DATA:  if (w_fire && last_beat) state_nxt = S_RESP;
      S_RESP:  if (b_fire)              state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // Output logic: handshake outputs are decoded from the next state and registered below.
  always_comb begin
    awready_nxt = (state_nxt == S_IDLE);
    wready_nxt  = (state_nxt == S_DATA);
    bvalid_nxt  = (state_nxt == S_RESP);
    bresp_nxt   = ((state_nxt == S_RESP) && err_nxt) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      awready_q <= awready_nxt;
      wready_q  <= wready_nxt;
      bvalid_q  <= bvalid_nxt;
      bresp_q   <= bresp_nxt;
    end
  end

  // WRAP keeps the high index bits and rolls the low log2(AWLEN+1) bits.
  always_comb begin
    idx_nxt = idx_q;
    unique case (burst_q)
      2'b00:   idx_nxt = idx_q;
      2'b10:   idx_nxt = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
      default: idx_nxt = idx_q + IDX_W'(1);
    endcase
  end

  always_comb begin
    err_nxt = err_q;
    if (aw_fire) begin
      err_nxt = 1'b0;
    end else if (w_fire && ((WLAST != last_beat) || !in_range || burst_bad)) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q       <= '0;
      beat_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (aw_fire) begin
        id_q       <= AWID;
        idx_q      <= aw_idx;
        len_q      <= AWLEN;
        burst_q    <= AWBURST;
        beat_cnt_q <= 8'd0;
      end else if (w_fire) begin
        idx_q      <= idx_nxt;
        beat_cnt_q <= last_beat ? 8'd0 : beat_cnt_q + 8'd1;
      end
    end
  end

  // Memory: byte-lane writes, never reset
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (WSTRB[i]) begin
          mem[idx_q[MEM_AW-1:0]][8*i +: 8] <= WDATA[8*i +: 8];
        end
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule
